spcpu_grp1_exec_unit: RTL and testbench
=======================================

// Module: spcpu_grp1_exec_unit
// PURPOSE
//  Decode-and-execute slice of the spcpu core. Classifies a 16-bit instruction word into its instruction group and decodes group-1 fields.
//  Executes group-1 register/immediate ALU ops against a 16 x 8-bit register file and a 4-bit processor-flags register.
//  Sits between the instruction fetch path (data_inout) and the main CPU state machine.
//  Other groups are only classified and reported; they are not executed here.
// PARAMETERS
//  none (register width 8, 16 registers, 4 flags, 16-bit instruction fixed)
// PORTS
//  clk            in   1   single clock; all state on posedge
//  reset          in   1   synchronous, active-high
//  instr_in       in   16  instruction word (high half of 32-bit instrs)
//  instr_valid    in   1   instr_in valid this cycle; execute if group 1
//  group_out      out  3   comb: 0=unknown,1..5=group 1..5
//  is_32_bit      out  1   comb: group_out==5
//  g1_opcode      out  3   comb: instr_in[14:12]
//  g1_ra_index    out  4   comb: instr_in[11:8]
//  g1_imm8        out  8   comb: instr_in[7:0]
//  changes_pc     out  1   comb: grp 1, op!=cmpi, ra_index is 14 or 15 (pc pair r14:r15)
//  rd_index       in   4   debug/read port address
//  rd_data        out  8   comb: cpu_regs[rd_index]
//  proc_flags     out  4   {Z,C,V,N} = bits [3:0]
//  exec_done      out  1   1-cycle registered pulse: group-1 op committed
//  unknown_instr  out  1   1-cycle registered pulse: valid word with group 0
// BEHAVIOUR
//  Group decode, first match wins:
//   [15]=0 -> 1; [15:14]=10 -> 2; [15:13]=110 -> 3; [15:12]=1110 -> 4; [15:11]=11110 -> 5; else 0.
//  Group-1 format 0ooo aaaa iiii iiii.
//  Group-1 opcodes: 0 addi, 1 adci, 2 subi, 3 sbci, 4 cmpi, 5 andi, 6 orri, 7 cpyi.
//  ALU (internal, comb), a = cpu_regs[ra], b = imm8, all 8-bit with carry-out into C:
//   addi r=a+b; adci r=a+b+C.
//   subi r=a+~b+1; sbci r=a+~b+C; cmpi = subi, result discarded.
//   C = carry out; for subtracts C=1 means no borrow.
//   V add: a7==b7 && r7!=a7. V sub: a7!=b7 && r7!=a7.
//   Z = (r==0); N = r7.
//   andi/orri: r=a&b / a|b; update Z,N only; C,V held.
//   cpyi: r=b; flags unchanged.
//  Commit on posedge when instr_valid && group_out==1 && !reset:
//   cpu_regs[ra]<=r (except cmpi).
//   proc_flags<=new flags per op.
//   exec_done<=1.
//  instr_valid with group 2..5: no state change, exec_done=0, unknown_instr=0.
//  instr_valid with group 0: no state change, unknown_instr<=1.
//  exec_done/unknown_instr deassert the cycle after any cycle without the triggering condition.
//  Latency: result visible on rd_data/proc_flags 1 cycle after instr_valid.
//  Back-to-back group-1 ops every cycle supported; each reads committed state from the previous cycle (no hazard).
//  Reset (sync): all 16 regs=0, proc_flags=0, exec_done=0, unknown_instr=0. Reset wins over a simultaneous instr_valid; mid-stream reset discards the in-flight op.
//  8-bit wrap-around on all results; carry beyond bit 8 is only C.
// TESTING
//  reset high 1 cycle -> every rd_data=0x00, proc_flags=0, exec_done=0.
//  0x037F then 0x0301 (addi r3) -> r3=0x80, flags Z0 C0 V1 N1, exec_done pulse each.
//  0x2201 (subi r2,1) on r2=0 -> r2=0xFF, Z0 C0 V0 N1.
//  cpyi r5,0x42 (0x7542) then cmpi r5,0x42 (0x4542) -> r5 stays 0x42, Z1 C1 V0 N0.
//  group decode: 0x8000->2, 0xC000->3, 0xE000->4, 0xF000->5 with is_32_bit=1.
//  0xF800 -> unknown_instr pulse; no reg or flag change.
//  0x7E12 (cpyi r14) -> changes_pc=1, r14=0x12.
//  Same word with reset high -> no commit.

Source files
------------

// File: rtl/spcpu_grp1_exec_unit_if.sv
// Bus bundle between the fetch path, the CPU state machine and the
// group-1 exec slice: instruction in, decode fields, register/flag view.
interface spcpu_grp1_exec_unit_if;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic [2:0]  group_out;
  logic        is_32_bit;
  logic [2:0]  g1_opcode;
  logic [3:0]  g1_ra_index;
  logic [7:0]  g1_imm8;
  logic        changes_pc;
  logic [3:0]  rd_index;
  logic [7:0]  rd_data;
  logic [3:0]  proc_flags;
  logic        exec_done;
  logic        unknown_instr;

  modport master (
    output instr_in, instr_valid, rd_index,
    input  group_out, is_32_bit, g1_opcode, g1_ra_index,
    input  g1_imm8, changes_pc, rd_data, proc_flags,
    input  exec_done, unknown_instr
  );

  modport slave (
    input  instr_in, instr_valid, rd_index,
    output group_out, is_32_bit, g1_opcode, g1_ra_index,
    output g1_imm8, changes_pc, rd_data, proc_flags,
    output exec_done, unknown_instr
  );
endinterface

// File: rtl/spcpu_grp1_exec_unit.sv
// Group classify + group-1 decode/execute against 16x8 regs and {Z,C,V,N}.
// Ports: clk, reset (sync, active-high), bus (slave side of the bundle).
module spcpu_grp1_exec_unit (
  input  logic                   clk,
  input  logic                   reset,
  spcpu_grp1_exec_unit_if.slave  bus
);

  localparam logic [2:0] OP_ADDI = 3'd0;
  localparam logic [2:0] OP_ADCI = 3'd1;
  localparam logic [2:0] OP_SUBI = 3'd2;
  localparam logic [2:0] OP_SBCI = 3'd3;
  localparam logic [2:0] OP_CMPI = 3'd4;
  localparam logic [2:0] OP_ANDI = 3'd5;
  localparam logic [2:0] OP_ORRI = 3'd6;

  logic [7:0]  regs_q [16];
  logic [3:0]  flags_q, flags_d;
  logic        done_q, done_d;
  logic        unk_q, unk_d;

  logic [15:0] ins;
  logic [2:0]  grp;
  logic [2:0]  op;
  logic [3:0]  ra;
  logic [7:0]  a, b, bx, res;
  logic        cin, is_sub, wr_en, commit;
  logic [8:0]  sum;
  logic        z, v_add, v_sub;

  assign ins = bus.instr_in;
  assign op  = ins[14:12];
  assign ra  = ins[11:8];
  assign b   = ins[7:0];
  assign a   = regs_q[ra];

  // First match wins: count leading ones.
  always_comb begin
    grp = 3'd0;
    if (!ins[15])      grp = 3'd1;
    else if (!ins[14]) grp = 3'd2;
    else if (!ins[13]) grp = 3'd3;
    else if (!ins[12]) grp = 3'd4;
    else if (!ins[11]) grp = 3'd5;
  end

  // Subtract is a + ~b + cin; C set means no borrow.
  always_comb begin
    is_sub = (op == OP_SUBI) || (op == OP_SBCI) || (op == OP_CMPI);
    bx     = is_sub ? ~b : b;
    cin    = 1'b0;
    if (op == OP_ADCI || op == OP_SBCI) cin = flags_q[2];
    else if (op == OP_SUBI || op == OP_CMPI) cin = 1'b1;
    sum    = {1'b0, a} + {1'b0, bx} + {8'd0, cin};
  end

  always_comb begin
    res = sum[7:0];
    if (op == OP_ANDI)      res = a & b;
    else if (op == OP_ORRI) res = a | b;
    else if (op == 3'd7)    res = b;
  end

  assign z     = (res == 8'd0);
  assign v_add = (a[7] == b[7]) && (res[7] != a[7]);
  assign v_sub = (a[7] != b[7]) && (res[7] != a[7]);

  always_comb begin
    flags_d = flags_q;
    unique case (op)
      OP_ADDI, OP_ADCI:
        flags_d = {z, sum[8], v_add, res[7]};
      OP_SUBI, OP_SBCI, OP_CMPI:
        flags_d = {z, sum[8], v_sub, res[7]};
      OP_ANDI, OP_ORRI:
        flags_d = {z, flags_q[2], flags_q[1], res[7]};
      default:
        flags_d = flags_q;
    endcase
  end

  assign wr_en  = (op != OP_CMPI);
  assign commit = bus.instr_valid && (grp == 3'd1);
  assign done_d = commit;
  assign unk_d  = bus.instr_valid && (grp == 3'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= 8'd0;
      flags_q <= 4'd0;
      done_q  <= 1'b0;
      unk_q   <= 1'b0;
    end else begin
      done_q <= done_d;
      unk_q  <= unk_d;
      if (commit) begin
        if (wr_en) regs_q[ra] <= res;
        flags_q <= flags_d;
      end
    end
  end

  assign bus.group_out     = grp;
  assign bus.is_32_bit     = (grp == 3'd5);
  assign bus.g1_opcode     = op;
  assign bus.g1_ra_index   = ra;
  assign bus.g1_imm8       = b;
  // r14:r15 hold the pc, so writing either redirects flow.
  assign bus.changes_pc    = (grp == 3'd1) && wr_en && (ra[3:1] == 3'b111);
  assign bus.rd_data       = regs_q[bus.rd_index];
  assign bus.proc_flags    = flags_q;
  assign bus.exec_done     = done_q;
  assign bus.unknown_instr = unk_q;

endmodule

// File: tb/tb_spcpu_grp1_exec_unit.sv
// Bench for spcpu_grp1_exec_unit: vector table with a scoreboard queue
// of post-commit expectations, plus reset corner sequences.
module tb_spcpu_grp1_exec_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_pass = 0;
  int   n_tot  = 0;

  spcpu_grp1_exec_unit_if bus ();

  spcpu_grp1_exec_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ins;
    logic        vld;
    logic [2:0]  grp;
    logic        pc;
    logic [3:0]  ri;
    logic [7:0]  rv;
    logic [3:0]  fl;
    logic        dn;
    logic        uk;
  } vec_t;

  typedef struct {
    logic [3:0] ri;
    logic [7:0] rv;
    logic [3:0] fl;
    logic       dn;
    logic       uk;
  } exp_t;

  vec_t tv [19];
  exp_t sb [$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  initial begin
    exp_t e;
    // flags are {Z,C,V,N}
    tv[0]  = '{16'h037F, 1'b1, 3'd1, 1'b0, 4'd3,  8'h7F, 4'b0000, 1'b1, 1'b0};
    tv[1]  = '{16'h0301, 1'b1, 3'd1, 1'b0, 4'd3,  8'h80, 4'b0011, 1'b1, 1'b0};
    tv[2]  = '{16'h2201, 1'b1, 3'd1, 1'b0, 4'd2,  8'hFF, 4'b0001, 1'b1, 1'b0};
    tv[3]  = '{16'h7542, 1'b1, 3'd1, 1'b0, 4'd5,  8'h42, 4'b0001, 1'b1, 1'b0};
    tv[4]  = '{16'h4542, 1'b1, 3'd1, 1'b0, 4'd5,  8'h42, 4'b1100, 1'b1, 1'b0};
    tv[5]  = '{16'h8000, 1'b1, 3'd2, 1'b0, 4'd5,  8'h42, 4'b1100, 1'b0, 1'b0};
    tv[6]  = '{16'hC000, 1'b1, 3'd3, 1'b0, 4'd5,  8'h42, 4'b1100, 1'b0, 1'b0};
    tv[7]  = '{16'hE000, 1'b1, 3'd4, 1'b0, 4'd5,  8'h42, 4'b1100, 1'b0, 1'b0};
    tv[8]  = '{16'hF000, 1'b1, 3'd5, 1'b0, 4'd5,  8'h42, 4'b1100, 1'b0, 1'b0};
    tv[9]  = '{16'hF800, 1'b1, 3'd0, 1'b0, 4'd3,  8'h80, 4'b1100, 1'b0, 1'b1};
    tv[10] = '{16'h7E12, 1'b1, 3'd1, 1'b1, 4'd14, 8'h12, 4'b1100, 1'b1, 1'b0};
    tv[11] = '{16'h1301, 1'b1, 3'd1, 1'b0, 4'd3,  8'h82, 4'b0001, 1'b1, 1'b0};
    tv[12] = '{16'h3301, 1'b1, 3'd1, 1'b0, 4'd3,  8'h80, 4'b0101, 1'b1, 1'b0};
    tv[13] = '{16'h53F0, 1'b1, 3'd1, 1'b0, 4'd3,  8'h80, 4'b0101, 1'b1, 1'b0};
    tv[14] = '{16'h630F, 1'b1, 3'd1, 1'b0, 4'd3,  8'h8F, 4'b0101, 1'b1, 1'b0};
    tv[15] = '{16'h5300, 1'b1, 3'd1, 1'b0, 4'd3,  8'h00, 4'b1100, 1'b1, 1'b0};
    tv[16] = '{16'h0301, 1'b0, 3'd1, 1'b0, 4'd3,  8'h00, 4'b1100, 1'b0, 1'b0};
    tv[17] = '{16'h0FFF, 1'b1, 3'd1, 1'b1, 4'd15, 8'hFF, 4'b0001, 1'b1, 1'b0};
    tv[18] = '{16'h4F00, 1'b1, 3'd1, 1'b0, 4'd15, 8'hFF, 4'b0101, 1'b1, 1'b0};

    reset           = 1'b1;
    bus.instr_in    = 16'h0000;
    bus.instr_valid = 1'b0;
    bus.rd_index    = 4'd0;
    @(posedge clk);
    #1;
    for (int r = 0; r < 16; r++) begin
      bus.rd_index = r[3:0];
      #1;
      chk($sformatf("rst_r%0d", r), 32'(bus.rd_data), 32'h0);
    end
    chk("rst_flags", 32'(bus.proc_flags), 32'h0);
    chk("rst_done", 32'(bus.exec_done), 32'h0);
    chk("rst_unk", 32'(bus.unknown_instr), 32'h0);

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 19; i++) begin
      bus.instr_in    = tv[i].ins;
      bus.instr_valid = tv[i].vld;
      bus.rd_index    = tv[i].ri;
      #1;
      chk($sformatf("grp%0d", i), 32'(bus.group_out), 32'(tv[i].grp));
      chk($sformatf("is32_%0d", i), 32'(bus.is_32_bit),
          32'(tv[i].grp == 3'd5));
      chk($sformatf("pc%0d", i), 32'(bus.changes_pc), 32'(tv[i].pc));
      sb.push_back('{tv[i].ri, tv[i].rv, tv[i].fl, tv[i].dn, tv[i].uk});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk($sformatf("sb_empty%0d", i), 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("rd%0d", i), 32'(bus.rd_data), 32'(e.rv));
        chk($sformatf("fl%0d", i), 32'(bus.proc_flags), 32'(e.fl));
        chk($sformatf("dn%0d", i), 32'(bus.exec_done), 32'(e.dn));
        chk($sformatf("uk%0d", i), 32'(bus.unknown_instr), 32'(e.uk));
      end
      @(negedge clk);
    end

    // pulses drop once valid goes away
    bus.instr_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("done_drop", 32'(bus.exec_done), 32'h0);
    chk("unk_drop", 32'(bus.unknown_instr), 32'h0);

    // load r3, then reset together with a valid op: reset wins
    @(negedge clk);
    bus.instr_in    = 16'h0355;
    bus.instr_valid = 1'b1;
    bus.rd_index    = 4'd3;
    @(posedge clk);
    #1;
    chk("pre_rst_r3", 32'(bus.rd_data), 32'h55);
    @(negedge clk);
    reset        = 1'b1;
    bus.instr_in = 16'h0301;
    @(posedge clk);
    #1;
    chk("rst_win_r3", 32'(bus.rd_data), 32'h0);
    chk("rst_win_fl", 32'(bus.proc_flags), 32'h0);
    chk("rst_win_dn", 32'(bus.exec_done), 32'h0);
    bus.rd_index = 4'd14;
    #1;
    chk("rst_win_r14", 32'(bus.rd_data), 32'h0);

    // first op after reset commits normally
    @(negedge clk);
    reset        = 1'b0;
    bus.rd_index = 4'd3;
    @(posedge clk);
    #1;
    chk("post_rst_r3", 32'(bus.rd_data), 32'h01);
    chk("post_rst_dn", 32'(bus.exec_done), 32'h1);
    @(negedge clk);
    bus.instr_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
